fib_job_scheduler: RTL and testbench

- Front-end sequencer for the stack-based Fibonacci engine.
- Accepts tagged compute requests over a valid/ready interface and buffers them in a small FIFO.
- Runs one job at a time on the single engine: holds the engine in reset, presents the operand, releases reset, then waits for the engine's sticky done or a timeout.
- Returns a tagged result, with an error flag on timeout, over a valid/ready response interface.

---
 rtl/fib_job_scheduler_if.sv | 35 +++
 rtl/fib_job_scheduler.sv | 165 ++++++++++++++++
 tb/tb_fib_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_job_scheduler_if.sv
// rtl/fib_job_scheduler_if.sv - request/response handshake bundle for the Fibonacci job scheduler
//
// Purpose: groups the tagged request channel and the tagged response channel.
// Ports (signals):
//   req_valid/req_ready/req_n/req_tag              request channel (master -> slave)
//   res_valid/res_ready/res_data/res_tag/res_err/res_cycles  response channel (slave -> master)
// Modports: master = job submitter/consumer, slave = scheduler.

interface fib_job_scheduler_if #(
    parameter int N_W   = 8,
    parameter int RES_W = 16,
    parameter int TAG_W = 2,
    parameter int CNT_W = 13
);
    logic             req_valid;
    logic             req_ready;
    logic [N_W-1:0]   req_n;
    logic [TAG_W-1:0] req_tag;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic [CNT_W-1:0] res_cycles;

    modport master (
        output req_valid, req_n, req_tag, res_ready,
        input  req_ready, res_valid, res_data, res_tag, res_err, res_cycles
    );

    modport slave (
        input  req_valid, req_n, req_tag, res_ready,
        output req_ready, res_valid, res_data, res_tag, res_err, res_cycles
    );
endinterface

// File: rtl/fib_job_scheduler.sv
// rtl/fib_job_scheduler.sv - FIFO-buffered one-job-at-a-time sequencer for the Fibonacci engine
//
// Purpose: queues tagged requests, runs each on the single engine (reset, load
// operand, release, wait for sticky done or timeout) and returns a tagged result.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus (slave)    request and response handshake channels
//   eng_rst        engine reset (high except while a job runs)
//   eng_n          operand presented to the engine
//   eng_done       engine sticky done
//   eng_result     engine result register
//   busy           scheduler not idle
//   q_count        request FIFO occupancy

module fib_job_scheduler #(
    parameter int N_W        = 8,
    parameter int RES_W      = 16,
    parameter int TAG_W      = 2,
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    fib_job_scheduler_if.slave       bus,
    output logic                     eng_rst,
    output logic [N_W-1:0]           eng_n,
    input  logic                     eng_done,
    input  logic [RES_W-1:0]         eng_result,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_MAX    = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t state, state_next;

    logic [N_W-1:0]   mem_n   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop;

    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] job_tag;
    logic             run_done, run_timeout;

    logic [RES_W-1:0] res_data_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             res_err_q;
    logic [CNT_W-1:0] res_cycles_q;

    // Acceptance depends only on occupancy, never on a same-cycle pop.
    assign bus.req_ready  = (count < FULL_COUNT);
    assign push           = bus.req_valid & bus.req_ready;
    assign q_count        = count;
    assign bus.res_data   = res_data_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_err    = res_err_q;
    assign bus.res_cycles = res_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Outputs decode directly from state so eng_rst follows the async reset
    // without waiting for an edge.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        run_done      = 1'b0;
        run_timeout   = 1'b0;
        eng_rst       = (state != RUN);
        busy          = (state != IDLE);
        bus.res_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) state_next = RUN;
            end
            RUN: begin
                // done is checked first so a completion on the last allowed cycle wins
                if (eng_done) begin
                    run_done   = 1'b1;
                    state_next = RESP;
                end else if (cnt == RUN_LAST) begin
                    run_timeout = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wr_ptr]   <= bus.req_n;
            mem_tag[wr_ptr] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One counter serves both the LOAD hold and the RUN cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_n        <= '0;
            job_tag      <= '0;
            cnt          <= '0;
            res_data_q   <= '0;
            res_tag_q    <= '0;
            res_err_q    <= 1'b0;
            res_cycles_q <= '0;
        end else if (pop) begin
            eng_n   <= mem_n[rd_ptr];
            job_tag <= mem_tag[rd_ptr];
            cnt     <= '0;
        end else if (state == LOAD) begin
            cnt <= (state_next == RUN) ? '0 : cnt + 1'b1;
        end else if (state == RUN) begin
            if (run_done) begin
                res_data_q   <= eng_result;
                res_tag_q    <= job_tag;
                res_err_q    <= 1'b0;
                res_cycles_q <= cnt;
            end else if (run_timeout) begin
                res_data_q   <= '0;
                res_tag_q    <= job_tag;
                res_err_q    <= 1'b1;
                res_cycles_q <= RUN_MAX;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb/tb_fib_job_scheduler.sv - self-checking bench for fib_job_scheduler with a stub engine

module tb_fib_job_scheduler;
    localparam int N_W = 8, RES_W = 16, TAG_W = 2, DEPTH = 4;
    localparam int RST_CYCLES = 2, TIMEOUT = 16, CNT_W = 5;

    typedef struct {
        logic [RES_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [CNT_W-1:0] cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fib_job_scheduler_if #(.N_W(N_W), .RES_W(RES_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    logic             eng_rst, eng_done, busy;
    logic [N_W-1:0]   eng_n;
    logic [RES_W-1:0] eng_result;
    logic [2:0]       q_count;

    fib_job_scheduler #(
        .N_W(N_W), .RES_W(RES_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .eng_rst(eng_rst), .eng_n(eng_n), .eng_done(eng_done),
        .eng_result(eng_result), .busy(busy), .q_count(q_count)
    );

    int total = 0;
    int bad   = 0;

    // dly[n]: number of RUN cycles the stub engine needs for operand n
    int               dly  [256];
    logic [RES_W-1:0] fibv [256];
    logic [7:0]       ecnt;

    always @(posedge clk) begin
        if (eng_rst)            ecnt <= 8'd0;
        else if (ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
    end
    assign eng_done   = !eng_rst && (int'(ecnt) >= dly[eng_n]);
    assign eng_result = fibv[eng_n];

    function automatic rsp_t model(input logic [N_W-1:0] n, input logic [TAG_W-1:0] tag);
        rsp_t r;
        r.tag = tag;
        if (dly[n] < TIMEOUT) begin
            r.data = fibv[n]; r.err = 1'b0; r.cyc = CNT_W'(dly[n]);
        end else begin
            r.data = '0; r.err = 1'b1; r.cyc = CNT_W'(TIMEOUT);
        end
        return r;
    endfunction

    // Tasks below begin and end just after a falling edge.
    task automatic push_one(input logic [N_W-1:0] n, input logic [TAG_W-1:0] tag, output bit ok);
        ok = 1'b0;
        bus.req_n = n; bus.req_tag = tag; bus.req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.req_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t got, output bit ok);
        ok = 1'b0;
        got = '{default: '0};
        for (int i = 0; i < 400; i++) begin
            if (bus.res_valid) begin
                got.data = bus.res_data; got.tag = bus.res_tag;
                got.err  = bus.res_err;  got.cyc = bus.res_cycles;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_n = '0; bus.req_tag = '0; bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_q_count got=%0d want=0", q_count); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (eng_rst !== 1'b1) begin bad++; $display("FAIL reset_eng_rst got=%b want=1", eng_rst); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        total++; if ({eng_n, bus.res_data, bus.res_tag, bus.res_err, bus.res_cycles} !== '0) begin
            bad++; $display("FAIL reset_regs got n=%h d=%h t=%h e=%b c=%h want all 0",
                            eng_n, bus.res_data, bus.res_tag, bus.res_err, bus.res_cycles);
        end
    endtask

    task automatic test_single();
        bit ok; rsp_t got; int loadcnt = 0;
        bus.res_ready = 1'b1;
        push_one(8'd6, 2'd2, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_push got=not_accepted want=accepted"); end
        for (int i = 0; i < 20; i++) begin
            if (!eng_rst) break;
            if (busy) loadcnt++;
            @(negedge clk);
        end
        total++; if (loadcnt != RST_CYCLES) begin bad++; $display("FAIL single_load_cycles got=%0d want=%0d", loadcnt, RST_CYCLES); end
        total++; if (eng_n !== 8'd6) begin bad++; $display("FAIL single_eng_n got=%0d want=6", eng_n); end
        wait_rsp(got, ok);
        total++; if (!ok || got.data !== 16'h0008 || got.tag !== 2'd2 || got.err !== 1'b0 || got.cyc !== 5'd9) begin
            bad++; $display("FAIL single_rsp got ok=%b d=%h t=%0d e=%b c=%0d want d=0008 t=2 e=0 c=9",
                            ok, got.data, got.tag, got.err, got.cyc);
        end
        @(negedge clk);
        total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_after_hs got valid=%b busy=%b want 0 0", bus.res_valid, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2; rsp_t got; logic rst_in_resp;
        bus.res_ready = 1'b1;
        push_one(8'd200, 2'd1, ok1);
        push_one(8'd6, 2'd3, ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL timeout_push got=%b%b want=11", ok1, ok2); end
        wait_rsp(got, ok1);
        rst_in_resp = eng_rst;
        total++; if (!ok1 || got.data !== 16'h0 || got.tag !== 2'd1 || got.err !== 1'b1 || got.cyc !== 5'd16) begin
            bad++; $display("FAIL timeout_rsp got ok=%b d=%h t=%0d e=%b c=%0d want d=0000 t=1 e=1 c=16",
                            ok1, got.data, got.tag, got.err, got.cyc);
        end
        total++; if (rst_in_resp !== 1'b1) begin bad++; $display("FAIL timeout_eng_rst_resp got=%b want=1", rst_in_resp); end
        @(negedge clk);
        wait_rsp(got, ok1);
        total++; if (!ok1 || got.data !== 16'h0008 || got.tag !== 2'd3 || got.err !== 1'b0 || got.cyc !== 5'd9) begin
            bad++; $display("FAIL timeout_next_rsp got ok=%b d=%h t=%0d e=%b c=%0d want d=0008 t=3 e=0 c=9",
                            ok1, got.data, got.tag, got.err, got.cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_done_at_timeout();
        bit ok; rsp_t got;
        bus.res_ready = 1'b1;
        push_one(8'd201, 2'd0, ok);
        wait_rsp(got, ok);
        total++; if (!ok || got.data !== 16'h1234 || got.err !== 1'b0 || got.cyc !== 5'd15) begin
            bad++; $display("FAIL done_vs_timeout got ok=%b d=%h e=%b c=%0d want d=1234 e=0 c=15",
                            ok, got.data, got.err, got.cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_full();
        bit ok; rsp_t first, got; int unstable = 0; int acc_miss = 0;
        logic [TAG_W-1:0] exp_tags [5];
        exp_tags[0] = 2'd0; exp_tags[1] = 2'd1; exp_tags[2] = 2'd2; exp_tags[3] = 2'd3; exp_tags[4] = 2'd0;
        bus.res_ready = 1'b0;
        push_one(8'd200, 2'd3, ok);
        wait_rsp(first, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_first_rsp got=none want=valid"); end
        for (int i = 0; i < 20; i++) begin
            if (i < 5) begin
                bus.req_valid = 1'b1; bus.req_n = 8'(10 + i); bus.req_tag = exp_tags[i];
                if (i < 4 && !bus.req_ready) acc_miss++;
            end
            if (!bus.res_valid || !eng_rst || !busy || bus.res_data !== first.data || bus.res_tag !== first.tag ||
                bus.res_err !== first.err || bus.res_cycles !== first.cyc) unstable++;
            @(negedge clk);
        end
        total++; if (acc_miss != 0) begin bad++; $display("FAIL bp_accept got=%0d_refused want=0", acc_miss); end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d_bad_cycles want=0", unstable); end
        total++; if (bus.req_ready !== 1'b0 || q_count !== 3'd4) begin
            bad++; $display("FAIL bp_full got ready=%b q=%0d want ready=0 q=4", bus.req_ready, q_count);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0 || q_count !== 3'd4) begin
            bad++; $display("FAIL bp_handshake got valid=%b busy=%b q=%0d want 0 0 4", bus.res_valid, busy, q_count);
        end
        @(negedge clk);
        total++; if (busy !== 1'b1 || q_count !== 3'd3 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL bp_pop got busy=%b q=%0d ready=%b want 1 3 1", busy, q_count, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL bp_fifth_accept got q=%0d want=4", q_count); end
        for (int k = 0; k < 5; k++) begin
            wait_rsp(got, ok);
            total++; if (!ok || got.tag !== exp_tags[k] || got !== model(8'(10 + k), exp_tags[k])) begin
                bad++; $display("FAIL bp_order_%0d got ok=%b t=%0d d=%h c=%0d want t=%0d", k, ok, got.tag,
                                got.data, got.cyc, exp_tags[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        rsp_t exp_q[$]; rsp_t got, exp;
        int sent = 0; int rcvd = 0; int jobs = 16;
        logic [N_W-1:0] n; logic [TAG_W-1:0] tag;
        n = 8'($urandom_range(0, 31)); tag = 2'($urandom);
        for (int cyc = 0; cyc < 3000 && rcvd < jobs; cyc++) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
            if (bus.res_valid && bus.res_ready) begin
                got.data = bus.res_data; got.tag = bus.res_tag; got.err = bus.res_err; got.cyc = bus.res_cycles;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected got t=%0d d=%h want=no_response", got.tag, got.data);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        bad++; $display("FAIL rand_rsp_%0d got d=%h t=%0d e=%b c=%0d want d=%h t=%0d e=%b c=%0d", rcvd,
                                        got.data, got.tag, got.err, got.cyc, exp.data, exp.tag, exp.err, exp.cyc);
                    end
                end
                rcvd++;
            end
            bus.req_valid = (sent < jobs) && ($urandom_range(0, 2) != 0);
            bus.req_n = n; bus.req_tag = tag;
            if (bus.req_valid && bus.req_ready) begin
                exp_q.push_back(model(n, tag));
                sent++;
                n = 8'($urandom_range(0, 31)); tag = 2'($urandom);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        total++; if (rcvd != jobs) begin bad++; $display("FAIL rand_complete got=%0d want=%0d", rcvd, jobs); end
    endtask

    task automatic test_reset_mid_run();
        bit ok0, ok1, ok2; int seen = 0; int waited = 0;
        bus.res_ready = 1'b1;
        push_one(8'd200, 2'd0, ok0);
        push_one(8'd201, 2'd1, ok1);
        push_one(8'd200, 2'd2, ok2);
        while (eng_rst && waited < 50) begin @(negedge clk); waited++; end
        total++; if (eng_rst !== 1'b0 || q_count !== 3'd2) begin
            bad++; $display("FAIL rmr_setup got eng_rst=%b q=%0d want 0 2", eng_rst, q_count);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (eng_rst !== 1'b1 || busy !== 1'b0 || q_count !== 3'd0) begin
            bad++; $display("FAIL rmr_async got eng_rst=%b busy=%b q=%0d want 1 0 0", eng_rst, busy, q_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (q_count !== 3'd0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmr_after got q=%0d valid=%b busy=%b want 0 0 0", q_count, bus.res_valid, busy);
        end
        for (int i = 0; i < 60; i++) begin
            if (bus.res_valid || busy) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rmr_stale got=%0d_active_cycles want=0", seen); end
    endtask

    initial begin
        logic [RES_W-1:0] a, b, t;
        a = '0; b = 16'd1;
        for (int i = 0; i < 256; i++) begin
            fibv[i] = a; t = a + b; a = b; b = t;
            dly[i] = $urandom_range(0, 20);
        end
        dly[6] = 9;
        dly[200] = 40;
        dly[201] = 15; fibv[201] = 16'h1234;
        for (int i = 10; i < 15; i++) dly[i] = 3;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_n = '0; bus.req_tag = '0; bus.res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_timeout();
        test_done_at_timeout();
        test_backpressure_full();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
